reg_file_write_decoder: RTL



---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_wr_arbiter.sv | 65 ++++++
 rtl/reg_file_write_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and the lane-numbering helper for the register-file write decoder.
package reg_file_pkg;

  localparam int REG_FILE_NUM_REGS  = 16;
  localparam int REG_FILE_REG_WIDTH = 16;
  localparam int REG_FILE_NUM_PORTS = 2;
  localparam int REG_FILE_BYTE_W    = 8;

  // Flat lane number of byte 'sel' inside register 'idx'.
  function automatic int lane_index(input int idx, input int sel, input int bytes);
    return idx * bytes + sel;
  endfunction

endpackage

// File: rtl/reg_file_wr_arbiter.sv
// Combinational per-lane priority select: replay candidates beat new ones,
// then the lower candidate index wins; winners are scattered onto their lanes.
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int NUM_REGS = 16,
  parameter int BYTES    = 2,
  parameter int IDX_W    = 4,
  parameter int SEL_W    = 1
) (
  input  logic [NUM_CAND-1:0]                            cand_valid_i,
  input  logic [NUM_CAND-1:0]                            cand_replay_i,
  input  logic [NUM_CAND*(IDX_W+SEL_W)-1:0]              cand_addr_i,
  input  logic [NUM_CAND*REG_FILE_BYTE_W-1:0]            cand_data_i,
  output logic [NUM_CAND-1:0]                            grant_o,
  output logic [NUM_REGS*BYTES-1:0]                      lane_valid_o,
  output logic [NUM_REGS*BYTES*REG_FILE_BYTE_W-1:0]      lane_data_o
);

  localparam int ADDR_W    = IDX_W + SEL_W;
  localparam int NUM_LANES = NUM_REGS * BYTES;
  localparam int BW        = REG_FILE_BYTE_W;

  logic [NUM_CAND-1:0] grant;

  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cand
    logic [NUM_CAND-1:0] beaten_by;
    for (genvar gj = 0; gj < NUM_CAND; gj++) begin : g_rival
      if (gj == gi) begin : g_self
        assign beaten_by[gj] = 1'b0;
      end else begin : g_other
        logic rival_first;
        assign rival_first = (cand_replay_i[gj] & ~cand_replay_i[gi]) |
                             ((cand_replay_i[gj] == cand_replay_i[gi]) & (gj < gi));
        assign beaten_by[gj] = cand_valid_i[gj] & rival_first &
                               (cand_addr_i[gj*ADDR_W +: ADDR_W] == cand_addr_i[gi*ADDR_W +: ADDR_W]);
      end
    end
    assign grant[gi] = cand_valid_i[gi] & ~(|beaten_by);
  end

  assign grant_o = grant;

  // At most one grant per lane, so OR-merging the granted bytes is exact.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic          lane_hit;
    logic [BW-1:0] lane_byte;
    always_comb begin
      lane_hit  = 1'b0;
      lane_byte = '0;
      for (int c = 0; c < NUM_CAND; c++) begin
        if (grant[c] &&
            lane_index(int'(cand_addr_i[c*ADDR_W+SEL_W +: IDX_W]),
                       int'(cand_addr_i[c*ADDR_W +: SEL_W]), BYTES) == gi) begin
          lane_hit  = 1'b1;
          lane_byte = lane_byte | cand_data_i[c*BW +: BW];
        end
      end
    end
    assign lane_valid_o[gi]          = lane_hit;
    assign lane_data_o[gi*BW +: BW]  = lane_byte;
  end

endmodule

// File: rtl/reg_file_write_decoder.sv
// Multi-port byte write decoder with per-port replay slots and registered outputs.
// Optional REG_FILE_WR_COLLISION_COUNT_EN adds a saturating collision_count output.
module reg_file_write_decoder
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS  = REG_FILE_NUM_REGS,
  parameter int REG_WIDTH = REG_FILE_REG_WIDTH,
  parameter int NUM_PORTS = REG_FILE_NUM_PORTS,
  localparam int BYTES  = REG_WIDTH / REG_FILE_BYTE_W,
  localparam int SEL_W  = (BYTES > 1) ? $clog2(BYTES) : 1,
  localparam int IDX_W  = $clog2(NUM_REGS),
  localparam int ADDR_W = IDX_W + SEL_W
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic [NUM_PORTS-1:0]                   wr_valid,
  output logic [NUM_PORTS-1:0]                   wr_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]            wr_addr,
  input  logic [NUM_PORTS*REG_FILE_BYTE_W-1:0]   wr_data,
  output logic [NUM_REGS*BYTES-1:0]              wen,
  output logic [NUM_REGS*REG_WIDTH-1:0]          data_out
`ifdef REG_FILE_WR_COLLISION_COUNT_EN
  ,
  output logic [15:0]                            collision_count
`endif
);

  localparam int NUM_CAND  = 2 * NUM_PORTS;
  localparam int NUM_LANES = NUM_REGS * BYTES;
  localparam int BW        = REG_FILE_BYTE_W;

  logic [NUM_PORTS-1:0]        replay_valid_q, replay_valid_d;
  logic [NUM_PORTS*ADDR_W-1:0] replay_addr_q,  replay_addr_d;
  logic [NUM_PORTS*BW-1:0]     replay_data_q,  replay_data_d;
  logic [NUM_LANES-1:0]        wen_q;
  logic [NUM_LANES*BW-1:0]     data_q;

  logic [NUM_PORTS-1:0]        accept;
  logic [NUM_PORTS-1:0]        new_ok;
  logic [NUM_CAND-1:0]         grant;
  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES*BW-1:0]     lane_data;

  assign wr_ready = reset_n ? ~replay_valid_q : {NUM_PORTS{1'b0}};
  assign accept   = wr_valid & wr_ready;

  // Out-of-range byte selects are accepted but never become candidates.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign new_ok[gi] = accept[gi] && (int'(wr_addr[gi*ADDR_W +: SEL_W]) < BYTES);
  end

  reg_file_wr_arbiter #(
    .NUM_CAND (NUM_CAND),
    .NUM_REGS (NUM_REGS),
    .BYTES    (BYTES),
    .IDX_W    (IDX_W),
    .SEL_W    (SEL_W)
  ) u_arbiter (
    .cand_valid_i  ({new_ok, replay_valid_q}),
    .cand_replay_i ({{NUM_PORTS{1'b0}}, {NUM_PORTS{1'b1}}}),
    .cand_addr_i   ({wr_addr, replay_addr_q}),
    .cand_data_i   ({wr_data, replay_data_q}),
    .grant_o       (grant),
    .lane_valid_o  (lane_valid),
    .lane_data_o   (lane_data)
  );

  always_comb begin
    replay_valid_d = replay_valid_q;
    replay_addr_d  = replay_addr_q;
    replay_data_d  = replay_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (replay_valid_q[p]) begin
        replay_valid_d[p] = ~grant[p];
      end else begin
        replay_valid_d[p]               = new_ok[p] & ~grant[NUM_PORTS+p];
        replay_addr_d[p*ADDR_W +: ADDR_W] = wr_addr[p*ADDR_W +: ADDR_W];
        replay_data_d[p*BW +: BW]         = wr_data[p*BW +: BW];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      replay_valid_q <= '0;
      replay_addr_q  <= '0;
      replay_data_q  <= '0;
      wen_q          <= '0;
      data_q         <= '0;
    end else begin
      replay_valid_q <= replay_valid_d;
      replay_addr_q  <= replay_addr_d;
      replay_data_q  <= replay_data_d;
      wen_q          <= lane_valid;
      data_q         <= lane_data;
    end
  end

  assign wen      = wen_q;
  assign data_out = data_q;

`ifdef REG_FILE_WR_COLLISION_COUNT_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;
  logic        new_lost;

  assign new_lost   = |(new_ok & ~grant[NUM_CAND-1:NUM_PORTS]);
  assign coll_cnt_d = (new_lost && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      coll_cnt_q <= '0;
    end else begin
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign collision_count = coll_cnt_q;
`endif

endmodule
